// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU control unit: ALUOp classes, R-type funct values,
// ALU control codes and the iterative-unit FSM encoding.
package alu_ctrl_pkg;

  localparam logic [2:0] ALUOP_BR    = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ADDI  = 3'b100;
  localparam logic [2:0] ALUOP_SLTI  = 3'b101;
  localparam logic [2:0] ALUOP_ADDIU = 3'b110;
  localparam logic [2:0] ALUOP_ORI   = 3'b111;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_MUL = 4'b0011;
  localparam logic [3:0] CTRL_DIV = 4'b0100;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef ALU_CTRL_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiplier and (with ALU_CTRL_DIV_EN) restoring
// divider sharing one accumulator / shift register pair and step counter.
module alu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
`ifdef ALU_CTRL_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             last_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q, opnd_q, res_lo_q, res_hi_q;
  logic [WIDTH-1:0] acc_d, mq_d;
  logic [WIDTH:0]   sum;
`ifdef ALU_CTRL_DIV_EN
  logic [WIDTH:0]   shifted, diff;
`endif

  // acc holds the high product / partial remainder, mq the low product / quotient.
  always_comb begin
    sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    acc_d = sum[WIDTH:1];
    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
`ifdef ALU_CTRL_DIV_EN
    shifted = {acc_q, mq_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_i) begin
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else if (load_i) begin
      cnt_q  <= CW'(WIDTH);
      acc_q  <= '0;
      mq_q   <= src2_i;
      opnd_q <= src1_i;
`ifdef ALU_CTRL_DIV_EN
      if (div_i) begin
        mq_q   <= src1_i;
        opnd_q <= src2_i;
      end
`endif
    end else if (step_i) begin
      cnt_q <= cnt_q - CW'(1);
      acc_q <= acc_d;
      mq_q  <= mq_d;
      if (last_o) begin
        res_lo_q <= mq_d;
        res_hi_q <= acc_d;
      end
    end
  end

  assign last_o      = (cnt_q == CW'(1));
  assign result_o    = res_lo_q;
  assign result_hi_o = res_hi_q;

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU control decode plus multi-cycle MUL sequencer; the DIV path is built only
// when ALU_CTRL_DIV_EN is defined.
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       funct_i,
  input  logic [2:0]       ALUOp_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [3:0]       ALUCtrl_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [1:0]       state_o
);
  state_e state_q, state_d;
  logic   is_mul, is_div, iter_op, load, step, last;

  always_comb begin
    ALUCtrl_o = CTRL_NOP;
    case (ALUOp_i)
      ALUOP_BR:    ALUCtrl_o = CTRL_SUB;
      ALUOP_ADDI:  ALUCtrl_o = CTRL_ADD;
      ALUOP_SLTI:  ALUCtrl_o = CTRL_SLT;
      ALUOP_ADDIU: ALUCtrl_o = CTRL_ADD;
      ALUOP_ORI:   ALUCtrl_o = CTRL_OR;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD:  ALUCtrl_o = CTRL_ADD;
          FUNCT_SUB:  ALUCtrl_o = CTRL_SUB;
          FUNCT_AND:  ALUCtrl_o = CTRL_AND;
          FUNCT_OR:   ALUCtrl_o = CTRL_OR;
          FUNCT_SLT:  ALUCtrl_o = CTRL_SLT;
          FUNCT_MULT: ALUCtrl_o = CTRL_MUL;
`ifdef ALU_CTRL_DIV_EN
          FUNCT_DIV:  ALUCtrl_o = CTRL_DIV;
`endif
          default:    ALUCtrl_o = CTRL_NOP;
        endcase
      end
      default:     ALUCtrl_o = CTRL_NOP;
    endcase
  end

  assign is_mul = (ALUOp_i == ALUOP_RTYPE) && (funct_i == FUNCT_MULT);
`ifdef ALU_CTRL_DIV_EN
  assign is_div = (ALUOp_i == ALUOP_RTYPE) && (funct_i == FUNCT_DIV);
`else
  assign is_div = 1'b0;
`endif
  assign iter_op = is_mul | is_div;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // start_i is only looked at in IDLE, so a start while busy is dropped.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && is_mul) begin
          state_d = ST_MUL;
          load    = 1'b1;
        end
`ifdef ALU_CTRL_DIV_EN
        else if (start_i && is_div) begin
          state_d = ST_DIV;
          load    = 1'b1;
        end
`endif
      end
      ST_MUL: begin
        step = 1'b1;
        if (last) state_d = ST_DONE;
      end
`ifdef ALU_CTRL_DIV_EN
      ST_DIV: begin
        step = 1'b1;
        if (last) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign stall_o = (rst_i && (state_q == ST_IDLE) && start_i && iter_op)
                 || (state_q == ST_MUL)
`ifdef ALU_CTRL_DIV_EN
                 || (state_q == ST_DIV)
`endif
                 ;
  assign state_o = state_q;

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .step_i      (step),
`ifdef ALU_CTRL_DIV_EN
    .div_i       ((state_q == ST_IDLE) ? is_div : (state_q == ST_DIV)),
`endif
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .last_o      (last),
    .result_o    (result_o),
    .result_hi_o (result_hi_o)
  );

endmodule
